// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes and FSM state encoding shared by lsu_subword and lsu_align.
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;
   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_READ  = ST_READ,
      S_WRITE = ST_WRITE,
      S_RESP  = ST_RESP
   } state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load extraction/extension, store merge and legality checks for one word lane.
// Misalignment is only flagged when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr,
   input  logic [31:0] rd_word,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_word,
   output logic        illegal,
   output logic        misaligned
);
   logic [4:0]  b_sh;
   logic [4:0]  h_sh;
   logic [7:0]  b;
   logic [15:0] h;
   assign b_sh = {addr, 3'b000};
   assign h_sh = {addr[1], 4'b0000};
   assign b    = 8'(rd_word >> b_sh);
   assign h    = 16'(rd_word >> h_sh);
   assign ld_data = funct3 == F3_B  ? {{24{b[7]}}, b}  :
                    funct3 == F3_H  ? {{16{h[15]}}, h} :
                    funct3 == F3_W  ? rd_word          :
                    funct3 == F3_BU ? {24'd0, b}       :
                    funct3 == F3_HU ? {16'd0, h}       : 32'd0;
   assign st_word = funct3 == F3_B ? (rd_word & ~(32'h0000_00ff << b_sh)) | ({24'd0, wdata[7:0]} << b_sh) :
                    funct3 == F3_H ? (rd_word & ~(32'h0000_ffff << h_sh)) | ({16'd0, wdata[15:0]} << h_sh) :
                    funct3 == F3_W ? wdata : rd_word;
   // Unsigned loads have no store counterpart
   assign illegal = !(funct3 inside {F3_B, F3_H, F3_W} || (!we && funct3 inside {F3_BU, F3_HU}));
`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = (funct3 inside {F3_H, F3_HU} && addr[0]) || (funct3 == F3_W && addr != 2'b00);
`else
   assign misaligned = 1'b0;
`endif
endmodule

// File: rtl/lsu_subword.sv
// lsu_subword: load/store unit doing sub-word stores as read-modify-write on a word-only memory.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses into error responses.
module lsu_subword
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [31:0]       mem_rd_data,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [31:0]       mem_wr_data,
   output logic              mem_we
);
   state_t            state, nxt;
   logic              we_r;
   logic [2:0]        f3_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r;
   logic              idle, accept, illegal, misaligned, bad;
   logic [31:0]       ld_data, st_word;
   assign idle      = state == S_IDLE;
   assign accept    = idle && req_valid;
   assign req_ready = idle;
   assign rsp_valid = state == S_RESP;
   assign mem_we    = state == S_WRITE;
   assign bad       = illegal || misaligned;
   // Legality is judged on the live request in IDLE, data paths use the latched request
   lsu_align u_align (
      .we         (idle ? req_we : we_r),
      .funct3     (idle ? req_funct3 : f3_r),
      .addr       (idle ? req_addr[1:0] : addr_r[1:0]),
      .rd_word    (mem_rd_data),
      .wdata      (wdata_r),
      .ld_data    (ld_data),
      .st_word    (st_word),
      .illegal    (illegal),
      .misaligned (misaligned)
   );
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  nxt = req_valid ? (bad ? S_RESP : S_READ) : S_IDLE;
         S_READ:  nxt = we_r ? S_WRITE : S_RESP;
         S_WRITE: nxt = S_RESP;
         S_RESP:  nxt = rsp_ready ? S_IDLE : S_RESP;
         default: nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         we_r        <= 1'b0;
         f3_r        <= 3'd0;
         addr_r      <= '0;
         wdata_r     <= 32'd0;
         rsp_rdata   <= 32'd0;
         rsp_err     <= 1'b0;
         mem_rd_addr <= '0;
         mem_wr_addr <= '0;
         mem_wr_data <= 32'd0;
      end else begin
         state <= nxt;
         if (accept) begin
            we_r      <= req_we;
            f3_r      <= req_funct3;
            addr_r    <= req_addr;
            wdata_r   <= req_wdata;
            rsp_rdata <= 32'd0;
            rsp_err   <= bad;
            if (!bad)
               mem_rd_addr <= {req_addr[ADDR_W-1:2], 2'b00};
         end
         if (state == S_READ) begin
            if (we_r) begin
               mem_wr_addr <= {addr_r[ADDR_W-1:2], 2'b00};
               mem_wr_data <= st_word;
            end else
               rsp_rdata <= ld_data;
         end
      end
   end
endmodule
